// File: rtl/sweep_pkg.sv
// sweep_pkg: shared FSM state type and settle-time limits for truth_table_sweeper.
package sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        EMIT,
        DONE
    } sweep_state_e;

    localparam int SWEEP_SETTLE_MAX = 15;

    // Settle timer reload value; out-of-range SETTLE is clamped to 1..SWEEP_SETTLE_MAX.
    function automatic logic [3:0] settle_load(input int s);
        return 4'((s < 1 ? 1 : (s > SWEEP_SETTLE_MAX ? SWEEP_SETTLE_MAX : s)) - 1);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// settle_timer: 4-bit loadable down-counter that flags expiry when it reaches 0.
//   clk, rst_n : clock, synchronous active-low reset
//   load_i     : load val_i (takes priority over counting)
//   en_i       : count down while nonzero
//   val_i      : reload value
//   expire_o   : counter is 0
module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [3:0] val_i,
    output logic       expire_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? val_i : (en_i && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= 4'd0;
        else        cnt_q <= cnt_d;
    end

    assign expire_o = cnt_q == 4'd0;

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input vector into a combinational DUT and checks it against a truth table.
//   clk, rst_n            : clock, synchronous active-low reset
//   start                 : sweep request, accepted only when idle or done
//   vec_o / dut_c_i       : DUT inputs (bit 1 = a, bit 0 = b) / DUT output
//   res_valid / res_ready : result stream handshake
//   res_vec/res_c/res_exp : vector, sampled output and expected output of the current result
//   busy, done, pass      : sweep status; pass = done with no mismatches
//   err_cnt               : mismatch count, saturating at 2^N_IN
// Macro SWEEP_STOP_ON_FAIL_EN: end the sweep after the first mismatching result is emitted.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int                    N_IN   = 2,
    parameter int                    SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0]  EXPECT = 4'b1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] vec_o,
    input  logic            dut_c_i,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [N_IN-1:0] res_vec,
    output logic            res_c,
    output logic            res_exp,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt
);

    localparam logic [N_IN-1:0] LAST    = '1;
    localparam logic [N_IN:0]   ERR_MAX = {1'b1, {N_IN{1'b0}}};
    localparam logic [3:0]      SET_LD  = settle_load(SETTLE);

    sweep_state_e    state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN:0]   err_q, err_d;
    logic            res_c_q, res_c_d, res_exp_q, res_exp_d;
    logic            load, expire, stop, exp_bit;

    settle_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .en_i    (state_q == DRIVE),
        .val_i   (SET_LD),
        .expire_o(expire)
    );

    assign exp_bit = EXPECT[vec_q];

`ifdef SWEEP_STOP_ON_FAIL_EN
    assign stop = vec_q == LAST || res_c_q != res_exp_q;
`else
    assign stop = vec_q == LAST;
`endif

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        err_d     = err_q;
        res_c_d   = res_c_q;
        res_exp_d = res_exp_q;
        load      = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = DRIVE;
                vec_d   = '0;
                err_d   = '0;
                load    = 1'b1;
            end
            DRIVE: if (expire) state_d = SAMPLE;
            SAMPLE: begin
                res_c_d   = dut_c_i;
                res_exp_d = exp_bit;
                err_d     = (dut_c_i != exp_bit && err_q != ERR_MAX) ? err_q + 1'b1 : err_q;
                state_d   = EMIT;
            end
            EMIT: if (res_ready) begin
                state_d = stop ? DONE : DRIVE;
                vec_d   = stop ? vec_q : vec_q + 1'b1;
                load    = !stop;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            err_q     <= '0;
            res_c_q   <= 1'b0;
            res_exp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            err_q     <= err_d;
            res_c_q   <= res_c_d;
            res_exp_q <= res_exp_d;
        end
    end

    assign vec_o     = vec_q;
    assign res_vec   = vec_q;
    assign res_c     = res_c_q;
    assign res_exp   = res_exp_q;
    assign res_valid = state_q == EMIT;
    assign busy      = state_q == DRIVE || state_q == SAMPLE || state_q == EMIT;
    assign done      = state_q == DONE;
    assign pass      = done && err_q == '0;
    assign err_cnt   = err_q;

endmodule
